seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 12 +
 rtl/seq_multiplier.sv | 86 ++++++++
 tb/tb_seq_multiplier.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
package seq_multiplier_pkg;
   localparam int N_DEFAULT = 32;
   localparam int FRAC_BITS = 19;
   localparam int TWO_PI    = (1 << FRAC_BITS) - 1;
   localparam int CNT_W     = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/seq_multiplier.sv
// Unsigned N x N shift-add multiplier, one partial product per clock,
// with a fixed-point slice of the product and a truncation flag.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int N    = N_DEFAULT,
   parameter int FRAC = FRAC_BITS
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic [2*N-1:0] product,
   output logic [N-1:0]   scaled,
   output logic           overflow,
   output logic           ready,
   output logic           done
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*N-1:0]     acc_q, acc_d;
   logic [2*N-1:0]     mcand_q, mcand_d;
   logic [N-1:0]       mplr_q, mplr_d;
   logic               done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = CNT_W'(N);
               acc_d   = '0;
               mcand_d = {{N{1'b0}}, multiplicand};
               mplr_d  = multiplier;
            end
         end
         ST_RUN: begin
            if (mplr_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d = {mcand_q[2*N-2:0], 1'b0};
            mplr_d  = {1'b0, mplr_q[N-1:1]};
            cnt_d   = cnt_q - CNT_W'(1);
            // Last step: result lands this edge, so flag it for exactly one cycle.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         done_q  <= done_d;
      end
   end

   assign ready    = (cnt_q == '0);
   assign done     = done_q;
   assign product  = acc_q;
   assign scaled   = acc_q[FRAC+N-1:FRAC];
   assign overflow = |acc_q[2*N-1:FRAC+N];

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed operand pairs with
// hand-computed products, latency, busy-ignore and reset-abort checks.
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] multiplicand = '0;
   logic [31:0] multiplier = '0;
   logic [63:0] product;
   logic [31:0] scaled;
   logic        overflow;
   logic        ready;
   logic        done;

   seq_multiplier dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .scaled       (scaled),
      .overflow     (overflow),
      .ready        (ready),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] p;
      logic [31:0] s;
      logic        ov;
      int          idx;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   edge_cnt = 0;
   int   last_accept = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(posedge clk) begin
      #1;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("product", product, e.p);
            chk("scaled", {32'd0, scaled}, {32'd0, e.s});
            chk("overflow", {63'd0, overflow}, {63'd0, e.ov});
            chk("latency", 64'(edge_cnt - e.idx), 64'd32);
            chk("ready_at_done", {63'd0, ready}, 64'd1);
            $display("result a*b=0x%h scaled=0x%h ov=%0d at edge %0d", product, scaled, overflow, edge_cnt);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] p, input logic [31:0] s, input logic ov);
      int w;
      exp_t e;
      w = 0;
      @(negedge clk);
      while (!ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!ready) begin
         chk("ready_timeout", 64'd0, 64'd1);
      end else begin
         start = 1'b1;
         multiplicand = a;
         multiplier = b;
         @(posedge clk);
         #1;
         e.p = p; e.s = s; e.ov = ov; e.idx = edge_cnt;
         exp_q.push_back(e);
         last_accept = edge_cnt;
         start = 1'b0;
         // Operands change during the run; the result must not notice.
         multiplicand = 32'hDEADBEEF;
         multiplier = 32'hCAFEF00D;
         $display("issue a=0x%h b=0x%h expect 0x%h at edge %0d", a, b, p, e.idx);
      end
   endtask

   initial begin
      int first_accept;
      int w;
      #1;
      chk("rst_ready", {63'd0, ready}, 64'd1);
      chk("rst_product", product, 64'd0);
      chk("rst_scaled", {32'd0, scaled}, 64'd0);
      chk("rst_overflow", {63'd0, overflow}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(32'd3, 32'd5, 64'd15, 32'd0, 1'b0);
      issue(32'd524287, 32'd4096, 64'd2147479552, 32'd4095, 1'b0);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFC000, 1'b1);
      issue(32'h00012345, 32'h00000100, 64'h0000000001234500, 32'h00000024, 1'b0);
      issue(32'h00080000, 32'hFFFFFFFF, 64'h0007FFFFFFF80000, 32'hFFFFFFFF, 1'b0);
      issue(32'h00100000, 32'h80000000, 64'h0008000000000000, 32'h00000000, 1'b1);

      // Busy: a start during RUN is dropped; the next accept lands in the done cycle.
      issue(32'd7, 32'd9, 64'd63, 32'd0, 1'b0);
      first_accept = last_accept;
      repeat (10) @(negedge clk);
      chk("busy_ready_low", {63'd0, ready}, 64'd0);
      start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
      @(negedge clk);
      start = 1'b0;
      issue(32'd2, 32'd2, 64'd4, 32'd0, 1'b0);
      chk("back_to_back_edge", 64'(last_accept - first_accept), 64'd33);

      // Reset abort mid-run: no done pulse, nothing retained.
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      start = 1'b1; multiplicand = 32'h0000FFFF; multiplier = 32'h0000FFFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (16) @(negedge clk);
      chk("abort_running", {63'd0, ready}, 64'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", {63'd0, ready}, 64'd1);
      chk("abort_product", product, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      $display("reset asserted mid-run at edge %0d", edge_cnt);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      issue(32'd0, 32'h00001234, 64'd0, 32'd0, 1'b0);
      chk("first_edge_accept", 64'(last_accept), 64'(edge_cnt));

      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      repeat (40) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
